// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: collects up to four BCD digits, commits them on enter,
// and holds the committed value until the consumer accepts it.
module keypad_entry_ctrl #(
   parameter logic [23:0] IDLE_TIMEOUT = 24'd10_000_000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [4:0]  KEY_IN,
   input  logic        press,
   output logic [15:0] VALUE,
   output logic        VALUE_VALID,
   input  logic        VALUE_READY,
   output logic [15:0] DIGITS,
   output logic [2:0]  COUNT,
   output logic        ERR,
   output logic        BUSY
);

   typedef enum logic [1:0] {StIdle, StEntry, StHold} state_e;

   localparam logic [3:0] KeyEnter = 4'hA;
   localparam logic [3:0] KeyBack  = 4'hB;
   localparam logic [3:0] KeyClear = 4'hC;

   state_e      state_q, state_d;
   logic        press_q;
   logic [15:0] digits_q, digits_d;
   logic [2:0]  count_q, count_d;
   logic [15:0] value_q, value_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
   logic [23:0] timer_q, timer_d;

   logic       accept;
   logic [3:0] key;
   logic       is_digit;

   assign accept   = press && !press_q && !KEY_IN[4];
   assign key      = KEY_IN[3:0];
   assign is_digit = (key <= 4'd9);

   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      count_d  = count_q;
      value_d  = value_q;
      valid_d  = valid_q;
      err_d    = 1'b0;
      timer_d  = 24'd0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (is_digit) begin
                  digits_d = {12'h000, key};
                  count_d  = 3'd1;
                  state_d  = StEntry;
               end else if (key == KeyEnter) begin
                  err_d = 1'b1;
               end
            end
         end
         StEntry: begin
            if (accept) begin
               // Any accepted key, including ignored D/E/F, restarts the inactivity timer.
               if (is_digit) begin
                  if (count_q < 3'd4) begin
                     digits_d = {digits_q[11:0], key};
                     count_d  = count_q + 3'd1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (key == KeyEnter) begin
                  value_d  = digits_q;
                  valid_d  = 1'b1;
                  digits_d = 16'h0000;
                  count_d  = 3'd0;
                  state_d  = StHold;
               end else if (key == KeyBack) begin
                  digits_d = {4'h0, digits_q[15:4]};
                  count_d  = count_q - 3'd1;
                  if (count_q == 3'd1) begin
                     state_d = StIdle;
                  end
               end else if (key == KeyClear) begin
                  digits_d = 16'h0000;
                  count_d  = 3'd0;
                  state_d  = StIdle;
               end
            end else if (timer_q == IDLE_TIMEOUT - 24'd1) begin
               digits_d = 16'h0000;
               count_d  = 3'd0;
               state_d  = StIdle;
            end else begin
               timer_d = timer_q + 24'd1;
            end
         end
         StHold: begin
            // Keys are dropped here; press_q still tracks press so a held key is not
            // re-accepted once the value is taken.
            if (VALUE_READY) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= StIdle;
         press_q  <= 1'b0;
         digits_q <= 16'h0000;
         count_q  <= 3'd0;
         value_q  <= 16'h0000;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         timer_q  <= 24'd0;
      end else begin
         state_q  <= state_d;
         press_q  <= press;
         digits_q <= digits_d;
         count_q  <= count_d;
         value_q  <= value_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         timer_q  <= timer_d;
      end
   end

   assign VALUE       = value_q;
   assign VALUE_VALID = valid_q;
   assign DIGITS      = digits_q;
   assign COUNT       = count_q;
   assign ERR         = err_q;
   assign BUSY        = busy_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl; a second instance with a short timeout
// covers the inactivity timer.
module tb_keypad_entry_ctrl;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic [4:0]  KEY_IN = 5'h1F;
   logic        press = 1'b0;
   logic        VALUE_READY = 1'b0;
   logic [15:0] VALUE, DIGITS;
   logic        VALUE_VALID, ERR, BUSY;
   logic [2:0]  COUNT;
   logic [15:0] t_value, t_digits;
   logic        t_valid, t_err, t_busy;
   logic [2:0]  t_count;

   int checks = 0;
   int passed = 0;

   always #5 CLK = ~CLK;

   keypad_entry_ctrl dut (
      .CLK(CLK), .RESET(RESET), .KEY_IN(KEY_IN), .press(press),
      .VALUE(VALUE), .VALUE_VALID(VALUE_VALID), .VALUE_READY(VALUE_READY),
      .DIGITS(DIGITS), .COUNT(COUNT), .ERR(ERR), .BUSY(BUSY)
   );

   keypad_entry_ctrl #(.IDLE_TIMEOUT(24'd16)) dut_t (
      .CLK(CLK), .RESET(RESET), .KEY_IN(KEY_IN), .press(press),
      .VALUE(t_value), .VALUE_VALID(t_valid), .VALUE_READY(VALUE_READY),
      .DIGITS(t_digits), .COUNT(t_count), .ERR(t_err), .BUSY(t_busy)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Press key k for n cycles, then release for one cycle.
   task automatic press_key(input logic [3:0] k, input int n);
      KEY_IN = {1'b0, k};
      press  = 1'b1;
      repeat (n) tick();
      press  = 1'b0;
      KEY_IN = 5'h1F;
      tick();
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      checks++;
      if ({VALUE, VALUE_VALID, DIGITS, COUNT, ERR, BUSY} !== 37'd0)
         $display("FAIL reset_outputs: got %h want 0",
                  {VALUE, VALUE_VALID, DIGITS, COUNT, ERR, BUSY});
      else passed++;
   endtask

   task automatic test_entry();
      press_key(4'h1, 5);
      checks++;
      if (DIGITS !== 16'h0001 || COUNT !== 3'd1 || BUSY !== 1'b1)
         $display("FAIL entry_1: DIGITS=%h COUNT=%0d BUSY=%b want 0001 1 1", DIGITS, COUNT, BUSY);
      else passed++;
      press_key(4'h2, 5);
      checks++;
      if (DIGITS !== 16'h0012) $display("FAIL entry_2: DIGITS got %h want 0012", DIGITS);
      else passed++;
      press_key(4'h3, 5);
      checks++;
      if (DIGITS !== 16'h0123 || COUNT !== 3'd3)
         $display("FAIL entry_3: DIGITS=%h COUNT=%0d want 0123 3", DIGITS, COUNT);
      else passed++;
      press_key(4'hA, 5);
      checks++;
      if (VALUE !== 16'h0123 || VALUE_VALID !== 1'b1 || COUNT !== 3'd0 || DIGITS !== 16'h0
          || BUSY !== 1'b1)
         $display("FAIL entry_commit: VALUE=%h VALID=%b COUNT=%0d DIGITS=%h BUSY=%b want 0123 1 0 0000 1",
                  VALUE, VALUE_VALID, COUNT, DIGITS, BUSY);
      else passed++;
   endtask

   task automatic test_hold();
      int bad = 0;
      // A key rises during HOLD and stays held through the handshake.
      KEY_IN = 5'h05;
      press  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (VALUE_VALID !== 1'b1 || ERR !== 1'b0 || VALUE !== 16'h0123) bad++;
      end
      checks++;
      if (bad != 0) $display("FAIL hold_stable: got %0d bad cycles want 0", bad);
      else passed++;
      VALUE_READY = 1'b1;
      tick();
      VALUE_READY = 1'b0;
      checks++;
      if (VALUE_VALID !== 1'b0 || BUSY !== 1'b0 || VALUE !== 16'h0123)
         $display("FAIL hold_release: VALID=%b BUSY=%b VALUE=%h want 0 0 0123",
                  VALUE_VALID, BUSY, VALUE);
      else passed++;
      repeat (3) tick();
      checks++;
      if (COUNT !== 3'd0 || BUSY !== 1'b0 || ERR !== 1'b0)
         $display("FAIL hold_held_key: COUNT=%0d BUSY=%b ERR=%b want 0 0 0", COUNT, BUSY, ERR);
      else passed++;
      press  = 1'b0;
      KEY_IN = 5'h1F;
      tick();
   endtask

   task automatic test_overflow();
      press_key(4'h9, 5);
      press_key(4'h8, 5);
      press_key(4'h7, 5);
      press_key(4'h6, 5);
      checks++;
      if (DIGITS !== 16'h9876 || COUNT !== 3'd4)
         $display("FAIL ovf_full: DIGITS=%h COUNT=%0d want 9876 4", DIGITS, COUNT);
      else passed++;
      KEY_IN = 5'h05;
      press  = 1'b1;
      tick();
      checks++;
      if (ERR !== 1'b1 || DIGITS !== 16'h9876)
         $display("FAIL ovf_err: ERR=%b DIGITS=%h want 1 9876", ERR, DIGITS);
      else passed++;
      tick();
      checks++;
      if (ERR !== 1'b0) $display("FAIL ovf_err_width: ERR got %b want 0", ERR);
      else passed++;
      press  = 1'b0;
      KEY_IN = 5'h1F;
      tick();
      press_key(4'hB, 5);
      checks++;
      if (DIGITS !== 16'h0987 || COUNT !== 3'd3)
         $display("FAIL ovf_back: DIGITS=%h COUNT=%0d want 0987 3", DIGITS, COUNT);
      else passed++;
      press_key(4'hC, 5);
      checks++;
      if (DIGITS !== 16'h0 || COUNT !== 3'd0 || BUSY !== 1'b0)
         $display("FAIL ovf_clear: DIGITS=%h COUNT=%0d BUSY=%b want 0000 0 0", DIGITS, COUNT, BUSY);
      else passed++;
   endtask

   task automatic test_idle_keys();
      KEY_IN = 5'h0A;
      press  = 1'b1;
      tick();
      checks++;
      if (ERR !== 1'b1 || VALUE_VALID !== 1'b0 || BUSY !== 1'b0)
         $display("FAIL idle_enter: ERR=%b VALID=%b BUSY=%b want 1 0 0", ERR, VALUE_VALID, BUSY);
      else passed++;
      tick();
      checks++;
      if (ERR !== 1'b0) $display("FAIL idle_enter_width: ERR got %b want 0", ERR);
      else passed++;
      press  = 1'b0;
      KEY_IN = 5'h1F;
      tick();
      press_key(4'h4, 1000);
      checks++;
      if (COUNT !== 3'd1 || DIGITS !== 16'h0004)
         $display("FAIL held_key: COUNT=%0d DIGITS=%h want 1 0004", COUNT, DIGITS);
      else passed++;
      press_key(4'hC, 2);
   endtask

   task automatic test_timeout();
      do_reset();
      press_key(4'h7, 1);
      repeat (14) tick();
      checks++;
      if (t_busy !== 1'b1 || t_digits !== 16'h0007)
         $display("FAIL to_before: BUSY=%b DIGITS=%h want 1 0007", t_busy, t_digits);
      else passed++;
      tick();
      checks++;
      if (t_busy !== 1'b0 || t_digits !== 16'h0 || t_count !== 3'd0 || t_err !== 1'b0)
         $display("FAIL to_expire: BUSY=%b DIGITS=%h COUNT=%0d ERR=%b want 0 0000 0 0",
                  t_busy, t_digits, t_count, t_err);
      else passed++;
      press_key(4'h7, 1);
      repeat (14) tick();
      KEY_IN = 5'h02;
      press  = 1'b1;
      tick();
      press  = 1'b0;
      KEY_IN = 5'h1F;
      checks++;
      if (t_digits !== 16'h0072 || t_count !== 3'd2 || t_busy !== 1'b1)
         $display("FAIL to_race: DIGITS=%h COUNT=%0d BUSY=%b want 0072 2 1",
                  t_digits, t_count, t_busy);
      else passed++;
      repeat (15) tick();
      checks++;
      if (t_busy !== 1'b1) $display("FAIL to_reload: BUSY got %b want 1", t_busy);
      else passed++;
      tick();
      checks++;
      if (t_busy !== 1'b0 || t_digits !== 16'h0)
         $display("FAIL to_expire2: BUSY=%b DIGITS=%h want 0 0000", t_busy, t_digits);
      else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      press_key(4'h1, 2);
      press_key(4'h2, 2);
      press_key(4'h3, 2);
      do_reset();
      tick();
      checks++;
      if ({VALUE, VALUE_VALID, DIGITS, COUNT, ERR, BUSY} !== 37'd0)
         $display("FAIL reset_entry: got %h want 0",
                  {VALUE, VALUE_VALID, DIGITS, COUNT, ERR, BUSY});
      else passed++;
      press_key(4'h1, 2);
      press_key(4'hA, 2);
      checks++;
      if (VALUE_VALID !== 1'b1 || VALUE !== 16'h0001)
         $display("FAIL reset_hold_pre: VALID=%b VALUE=%h want 1 0001", VALUE_VALID, VALUE);
      else passed++;
      RESET = 1'b1;
      tick();
      checks++;
      if ({VALUE, VALUE_VALID, DIGITS, COUNT, ERR, BUSY} !== 37'd0)
         $display("FAIL reset_hold: got %h want 0",
                  {VALUE, VALUE_VALID, DIGITS, COUNT, ERR, BUSY});
      else passed++;
      // Key already pressed when reset drops counts as a fresh press.
      KEY_IN = 5'h05;
      press  = 1'b1;
      tick();
      RESET = 1'b0;
      tick();
      checks++;
      if (DIGITS !== 16'h0005 || COUNT !== 3'd1)
         $display("FAIL reset_press: DIGITS=%h COUNT=%0d want 0005 1", DIGITS, COUNT);
      else passed++;
      press  = 1'b0;
      KEY_IN = 5'h1F;
      tick();
   endtask

   initial begin
      test_reset();
      test_entry();
      test_hold();
      test_overflow();
      test_idle_keys();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameter IDLE_TIMEOUT, default 24'd10_000_000, is the number of CLK cycles of inactivity in ENTRY before the entry is discarded.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 KEY_IN  input  5  key code from the keypad scanner.
  - {0,hex} = key valid, carrying the key value.
  - 5'h1F = no key.
REQ-005 press  input  1  level-high while the scanner reports a debounced key.
REQ-006 VALUE  output  16  committed 4-digit BCD number, right-aligned.
REQ-007 VALUE_VALID  output  1  VALUE holds a committed number awaiting the consumer.
REQ-008 VALUE_READY  input  1  consumer accepts VALUE.
REQ-009 DIGITS  output  16  live entry buffer (BCD, right-aligned) for display.
REQ-010 COUNT  output  3  number of digits currently entered, 0..4.
REQ-011 ERR  output  1  one-cycle pulse on a rejected key.
REQ-012 BUSY  output  1  high in ENTRY or HOLD.

Function
REQ-013 Key accept event SHALL occur on the cycle in which all of the following hold:
  - press=1;
  - registered press from the previous cycle = 0;
  - KEY_IN[4]=0.
  A press held high SHALL produce exactly one event; press rising with KEY_IN[4]=1 SHALL be ignored.
REQ-014 Key classes:
  - 0-9 = digit;
  - A = enter;
  - B = backspace;
  - C = clear;
  - D, E, F = ignored with no ERR.
REQ-015 FSM states: IDLE, ENTRY, HOLD.
REQ-016 IDLE transitions:
  - digit -> ENTRY, DIGITS={12'h000,d}, COUNT=1;
  - enter -> ERR pulse, stay IDLE;
  - backspace or clear -> no effect, stay IDLE.
REQ-017 ENTRY, digit key:
  - COUNT<4 -> DIGITS={DIGITS[11:0],d}, COUNT+1;
  - COUNT=4 -> ERR pulse, DIGITS unchanged.
REQ-018 ENTRY, backspace key: DIGITS={4'h0,DIGITS[15:4]}, COUNT-1; if COUNT becomes 0, go to IDLE.
REQ-019 ENTRY, clear key: DIGITS=0, COUNT=0, go to IDLE.
REQ-020 ENTRY, enter key: VALUE=DIGITS, VALUE_VALID=1, DIGITS=0, COUNT=0, go to HOLD.
REQ-021 Update timing: DIGITS, COUNT and VALUE SHALL update on the clock edge following the accept cycle. VALUE_VALID SHALL rise on that same edge (latency 1 cycle).
REQ-022 HOLD: VALUE and VALUE_VALID stable until a cycle with VALUE_READY=1. On that cycle's edge, VALUE_VALID=0 and the FSM goes to IDLE; VALUE keeps its last value.
REQ-023 HOLD, key accept events: all discarded with no ERR, including when coincident with VALUE_READY. The registered press SHALL still track press, so a held key is not re-accepted after HOLD exits.
REQ-024 VALUE_READY outside HOLD SHALL be ignored.
REQ-025 Inactivity timer in ENTRY:
  - counts CLK cycles and reloads to 0 on every accept event and on ENTRY entry;
  - at count = IDLE_TIMEOUT-1, DIGITS=0, COUNT=0, go to IDLE, no ERR.
  - Accept event on the timeout cycle: the key SHALL win and the timer reloads.
REQ-026 Timer SHALL be held at 0 in IDLE and HOLD.
REQ-027 ERR SHALL be high for exactly one cycle per rejected key, starting the edge after the accept cycle.
REQ-028 BUSY SHALL be a registered decode of state (ENTRY or HOLD).
REQ-029 Digit values SHALL be stored unmodified as 4-bit BCD. No binary conversion or arithmetic beyond the 3-bit COUNT and 24-bit timer.

Reset
REQ-030 While RESET=1 at a rising CLK edge, the following SHALL apply regardless of state, including mid-entry and in HOLD:
  - state=IDLE;
  - DIGITS=0, COUNT=0, VALUE=0;
  - VALUE_VALID=0, ERR=0, BUSY=0;
  - timer=0, registered press=0.
REQ-031 A press already high when RESET deasserts SHALL count as a rising edge on the first post-reset cycle.

Verification
REQ-032 Key 1, 2, 3, then A, each press high 5 cycles -> DIGITS sequence:
  - 0001, 0012, 0123;
  - then VALUE=16'h0123, VALUE_VALID=1, COUNT=0, BUSY=1.
REQ-033 In HOLD, hold VALUE_READY=0 for 10 cycles, then 1 for 1 cycle -> VALUE_VALID stays 1 for those 10 cycles, drops on the next edge, state IDLE, BUSY=0.
REQ-034 Keys 9, 8, 7, 6, 5 -> DIGITS=16'h9876, COUNT=4, ERR pulse of one cycle on key 5. Then B -> DIGITS=16'h0987, COUNT=3. Then C -> DIGITS=0, IDLE.
REQ-035 A in IDLE -> ERR one-cycle pulse, no VALUE_VALID. Key 4 with press held 1000 cycles -> COUNT=1 only.
REQ-036 IDLE_TIMEOUT=16: key 7 then no keys -> IDLE with DIGITS=0 on cycle 16 after accept. Repeat with a key 2 accept event landing on the timeout cycle -> DIGITS=16'h0072, COUNT=2, stays ENTRY.
REQ-037 RESET=1 for one cycle mid-entry (COUNT=3) and again in HOLD -> all outputs 0 on the next edge.
